abort_monitor: RTL and testbench
================================

# abort_monitor

Synthesizable controller that aborts a periodic worker and checks that the abort took effect. After `start` it counts `ABORT_AFTER` clocks and raises a held `abort` level. It then snapshots the worker's event count and watches a guard window of `GUARD_CYCLES` clocks. It reports pass if the worker stayed frozen and the snapshot equals `EXPECT_COUNT`, otherwise fail. It sits beside any event-counting worker in the kill/cleanup regression benches.

## Interface
- `CNT_W`, 8, width of worker event count
- `ABORT_AFTER`, 5, clocks from start accept to abort assertion; must be ≥1
- `GUARD_CYCLES`, 4, clocks the worker must stay frozen after snapshot; must be ≥1
- `EXPECT_COUNT`, 2, worker count required at snapshot

Ports:
- `clock` in 1: single clock; all logic on the rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `start` in 1: begin a check; sampled only in IDLE and DONE
- `worker_tick` in 1: one-cycle pulse per worker increment
- `worker_count` in CNT_W: worker's current event count
- `abort` out 1: kill request to the worker, held high from ABORT through DONE
- `busy` out 1: high in RUN, ABORT and GUARD
- `done` out 1: high in DONE
- `pass` out 1: valid when `done`=1
- `fail` out 1: valid when `done`=1; exactly one of `pass`/`fail` is high in DONE
- `snap_count` out CNT_W: worker count captured at abort

## Operation
- Reset (async, `reset_n`=0): state IDLE. `abort`, `busy`, `done`, `pass` and `fail` are 0; `snap_count`, the cycle counter and the violation flag are 0. Reset mid-operation discards the check immediately, with no completion.
- States: IDLE, RUN, ABORT, GUARD, DONE.
- IDLE: on `start`=1, go to RUN. The cycle counter and violation flag are cleared.
- RUN: the counter increments each clock. When it reaches `ABORT_AFTER`, go to ABORT; `abort` is registered high on that same edge.
- ABORT (one cycle): on the exit edge, `snap_count` takes `worker_count` as it stands before that edge. A `worker_tick` sampled on that edge sets the violation flag. The state then goes to GUARD and the counter clears.
- GUARD: the counter increments each clock. On every GUARD edge, `worker_tick`=1 or `worker_count`≠`snap_count` sets the violation flag (sticky). After `GUARD_CYCLES` edges, go to DONE.
- DONE: `done`=1 and `abort` stays 1.
  - `pass` = no violation and `snap_count`==`EXPECT_COUNT`.
  - `fail` is the complement of `pass`.
  - `start`=1 restarts directly into RUN: `abort`, `done`, `pass` and `fail` drop on that edge and the flags clear.
- `start` in RUN, ABORT or GUARD is ignored.
- Width rules:
  - The cycle counter is `$clog2(max(ABORT_AFTER,GUARD_CYCLES)+1)` bits.
  - All count compares are unsigned at `CNT_W`.
  - A worker count that wraps during GUARD still differs from the snapshot and is flagged.

## Timing
- Label the `start` accept edge E0.
- RUN spans edges E1..E`ABORT_AFTER`; `abort` is high after edge E`ABORT_AFTER`.
- The snapshot and the ABORT→GUARD transition happen at edge E`ABORT_AFTER`+1.
- DONE, `done` and `pass`/`fail` are visible after edge E(`ABORT_AFTER`+1+`GUARD_CYCLES`). With the default parameters this is E10.
- `busy` is high from after E0 until DONE is entered.
- Outputs are registered; there are no combinational input-to-output paths.
- Worker contract: a worker that sees `abort`=1 at an edge must not tick at that edge.

## Test plan
- Defaults, compliant worker (ticks every 2nd clock from E1, stops when it samples `abort`=1) -> ticks at E2, E4; `snap_count`=2, `done`=1 after E10, `pass`=1, `fail`=0.
- Worker ignores `abort` (continues ticking) -> tick at E6 flagged; `snap_count`=2, `fail`=1 after E10.
- Worker ticks every clock and honours `abort` -> `snap_count`=5, no guard violations; `fail`=1 because the count ≠ `EXPECT_COUNT`.
- `start` pulsed at E3 while in RUN -> ignored; `done` still rises after E10. Then `start` pulsed in DONE -> `done`, `abort` and `pass` drop next edge, and a second identical run passes.
- `reset_n` asserted low at E7, during GUARD -> all outputs 0 immediately and the state is IDLE. After release, `done` stays 0 until a new `start`.
- `worker_count` forced from 2 to 3 at E8 with no tick -> `fail`=1 after E10.

Source files
------------

// File: rtl/abort_monitor_if.sv
// Handshake bundle between the abort monitor and the bench/worker side.
// The monitor takes the slave view; whoever drives start and the worker uses master.
interface abort_monitor_if #(
    parameter int CNT_W = 8
);
    logic             start_i;
    logic             worker_tick_i;
    logic [CNT_W-1:0] worker_count_i;
    logic             abort_o;
    logic             busy_o;
    logic             done_o;
    logic             pass_o;
    logic             fail_o;
    logic [CNT_W-1:0] snap_count_o;

    modport master (
        output start_i, worker_tick_i, worker_count_i,
        input  abort_o, busy_o, done_o, pass_o, fail_o, snap_count_o
    );

    modport slave (
        input  start_i, worker_tick_i, worker_count_i,
        output abort_o, busy_o, done_o, pass_o, fail_o, snap_count_o
    );
endinterface

// File: rtl/abort_monitor.sv
// Aborts a periodic worker after a fixed delay, snapshots its event count and
// checks that it stays frozen for a guard window before reporting pass/fail.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start
// S_RUN   | counting clocks up to the abort point
// S_ABORT | abort held high; snapshot taken on the exit edge
// S_GUARD | worker must not tick or change count
// S_DONE  | result presented, abort still held; start restarts
module abort_monitor #(
    parameter int CNT_W        = 8,
    parameter int ABORT_AFTER  = 5,
    parameter int GUARD_CYCLES = 4,
    parameter int EXPECT_COUNT = 2
) (
    input  logic           clock,
    input  logic           reset_n,
    abort_monitor_if.slave bus
);
    localparam int MAX_CYC = (ABORT_AFTER > GUARD_CYCLES) ? ABORT_AFTER : GUARD_CYCLES;
    localparam int CYC_W   = $clog2(MAX_CYC + 1);

    localparam logic [CYC_W-1:0] ABORT_TC   = CYC_W'(ABORT_AFTER);
    localparam logic [CYC_W-1:0] GUARD_TC   = CYC_W'(GUARD_CYCLES);
    localparam logic [CNT_W-1:0] EXPECT_VAL = CNT_W'(EXPECT_COUNT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_ABORT,
        S_GUARD,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CYC_W-1:0] cnt_q, cnt_d;
    logic             viol_q, viol_d;
    logic [CNT_W-1:0] snap_q, snap_d;
    logic [CYC_W-1:0] cnt_inc;

    logic abort_c, busy_c, done_c, pass_c, fail_c;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            viol_q  <= 1'b0;
            snap_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            viol_q  <= viol_d;
            snap_q  <= snap_d;
        end
    end

    assign cnt_inc = cnt_q + CYC_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        viol_d  = viol_q;
        snap_d  = snap_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start_i) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    viol_d  = 1'b0;
                end
            end
            S_RUN: begin
                cnt_d = cnt_inc;
                if (cnt_inc == ABORT_TC) state_d = S_ABORT;
            end
            S_ABORT: begin
                // A tick on this edge means the worker ignored an abort it already saw.
                snap_d  = bus.worker_count_i;
                if (bus.worker_tick_i) viol_d = 1'b1;
                cnt_d   = '0;
                state_d = S_GUARD;
            end
            S_GUARD: begin
                cnt_d = cnt_inc;
                if (bus.worker_tick_i || (bus.worker_count_i != snap_q)) viol_d = 1'b1;
                if (cnt_inc == GUARD_TC) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decode registered state only, so no input reaches an output combinationally.
    always_comb begin
        abort_c = (state_q == S_ABORT) || (state_q == S_GUARD) || (state_q == S_DONE);
        busy_c  = (state_q == S_RUN) || (state_q == S_ABORT) || (state_q == S_GUARD);
        done_c  = (state_q == S_DONE);
        pass_c  = done_c && !viol_q && (snap_q == EXPECT_VAL);
        fail_c  = done_c && !pass_c;
    end

    assign bus.abort_o      = abort_c;
    assign bus.busy_o       = busy_c;
    assign bus.done_o       = done_c;
    assign bus.pass_o       = pass_c;
    assign bus.fail_o       = fail_c;
    assign bus.snap_count_o = snap_q;
endmodule

// File: tb/tb_abort_monitor.sv
// Directed bench for abort_monitor: worker behaviour is scripted edge by edge,
// expected results are hand-derived for the default parameters.
module tb_abort_monitor;
    logic clock;
    logic reset_n;
    logic [7:0] wcnt;
    int checks;
    int errors;

    abort_monitor_if #(.CNT_W(8)) wi ();

    abort_monitor #(
        .CNT_W(8),
        .ABORT_AFTER(5),
        .GUARD_CYCLES(4),
        .EXPECT_COUNT(2)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (wi.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge; the worker count follows a tick on the edge it is sampled.
    task automatic step(input logic t, input logic s);
        wi.worker_tick_i = t;
        wi.start_i       = s;
        @(posedge clock);
        #1;
        if (t) wcnt = wcnt + 8'd1;
        wi.worker_count_i = wcnt;
        wi.worker_tick_i  = 1'b0;
        wi.start_i        = 1'b0;
    endtask

    // n edges; bit i of pat is the tick on the i-th of them.
    task automatic steps(input int n, input logic [31:0] pat);
        for (int i = 0; i < n; i++) step(pat[i], 1'b0);
    endtask

    task automatic new_run();
        wcnt = 8'd0;
        wi.worker_count_i = wcnt;
        step(1'b0, 1'b1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        wcnt = 8'd0;
        reset_n = 1'b0;
        wi.start_i = 1'b0;
        wi.worker_tick_i = 1'b0;
        wi.worker_count_i = 8'd0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_done", 32'(wi.done_o), 32'd0);
        chk("rst_abort", 32'(wi.abort_o), 32'd0);
        chk("rst_busy", 32'(wi.busy_o), 32'd0);
        chk("rst_pass_fail", {30'd0, wi.pass_o, wi.fail_o}, 32'd0);
        chk("rst_snap", 32'(wi.snap_count_o), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        #1;

        // Compliant worker, ticks at E2 and E4
        new_run();
        chk("c1_busy_e0", 32'(wi.busy_o), 32'd1);
        steps(4, 32'h0000_000A);
        chk("c1_abort_e4", 32'(wi.abort_o), 32'd0);
        step(1'b0, 1'b0);
        chk("c1_abort_e5", 32'(wi.abort_o), 32'd1);
        step(1'b0, 1'b0);
        chk("c1_snap_e6", 32'(wi.snap_count_o), 32'd2);
        steps(3, 32'h0);
        chk("c1_done_e9", 32'(wi.done_o), 32'd0);
        chk("c1_busy_e9", 32'(wi.busy_o), 32'd1);
        step(1'b0, 1'b0);
        chk("c1_done_e10", 32'(wi.done_o), 32'd1);
        chk("c1_busy_e10", 32'(wi.busy_o), 32'd0);
        chk("c1_pass", 32'(wi.pass_o), 32'd1);
        chk("c1_fail", 32'(wi.fail_o), 32'd0);
        chk("c1_abort_done", 32'(wi.abort_o), 32'd1);

        // Worker ignores abort: ticks E2..E10 every other edge
        new_run();
        steps(10, 32'h0000_02AA);
        chk("c2_snap", 32'(wi.snap_count_o), 32'd2);
        chk("c2_done", 32'(wi.done_o), 32'd1);
        chk("c2_fail", 32'(wi.fail_o), 32'd1);
        chk("c2_pass", 32'(wi.pass_o), 32'd0);

        // Worker ticks every clock until abort is seen
        new_run();
        steps(10, 32'h0000_001F);
        chk("c3_snap", 32'(wi.snap_count_o), 32'd5);
        chk("c3_fail", 32'(wi.fail_o), 32'd1);

        // start during RUN ignored, then restart from DONE
        new_run();
        steps(2, 32'h0000_0002);
        step(1'b0, 1'b1);
        steps(7, 32'h0000_0001);
        chk("c4_done", 32'(wi.done_o), 32'd1);
        chk("c4_pass", 32'(wi.pass_o), 32'd1);
        new_run();
        chk("c4_restart_done", 32'(wi.done_o), 32'd0);
        chk("c4_restart_abort", 32'(wi.abort_o), 32'd0);
        chk("c4_restart_pass", 32'(wi.pass_o), 32'd0);
        chk("c4_restart_busy", 32'(wi.busy_o), 32'd1);
        steps(10, 32'h0000_000A);
        chk("c4_run2_done", 32'(wi.done_o), 32'd1);
        chk("c4_run2_pass", 32'(wi.pass_o), 32'd1);

        // Reset during GUARD
        new_run();
        steps(7, 32'h0000_000A);
        chk("c5_guard_busy", 32'(wi.busy_o), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("c5_rst_abort", 32'(wi.abort_o), 32'd0);
        chk("c5_rst_busy", 32'(wi.busy_o), 32'd0);
        chk("c5_rst_snap", 32'(wi.snap_count_o), 32'd0);
        chk("c5_rst_done", 32'(wi.done_o), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        steps(12, 32'h0);
        chk("c5_idle_done", 32'(wi.done_o), 32'd0);
        chk("c5_idle_busy", 32'(wi.busy_o), 32'd0);

        // Count changes 2->3 without a tick, sampled at E8
        new_run();
        steps(7, 32'h0000_000A);
        wcnt = 8'd3;
        wi.worker_count_i = wcnt;
        steps(3, 32'h0);
        chk("c6_snap", 32'(wi.snap_count_o), 32'd2);
        chk("c6_done", 32'(wi.done_o), 32'd1);
        chk("c6_fail", 32'(wi.fail_o), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
